// File: rtl/alu_wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_wb_stage_pkg
// Shared definitions for the ALU write-back stage:
//   - opcode encodings for the instructions that need special handling
//   - flag bit positions inside the packed flag register
//   - default number of extra cycles for multi-cycle ALU ops
//   - FSM state type for the multi-cycle controller
//   - helper that decides whether an opcode may write the register file
// ----------------------------------------------------------------------------
package alu_wb_stage_pkg;

   // Opcode encodings (6-bit), shared with the decoder and ALU
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_CMP  = 6'h05;
   localparam logic [5:0] OP_MUL  = 6'h08;
   localparam logic [5:0] OP_BTST = 6'h0c;
   localparam logic [5:0] OP_DJNZ = 6'h10;

   // Bit positions of the architectural flags in a 4-bit flag vector
   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_S = 3;

   // Default extra cycles held for an mcp op (legal 1..7)
   localparam int unsigned MCP_CYCLES_DEF = 1;

   typedef enum logic {StIdle, StWait} mcp_state_e;

   // CMP and BTST only produce flags; their result is never written back
   function automatic logic wen_allowed(input logic [5:0] opcode);
      return !((opcode == OP_CMP) || (opcode == OP_BTST));
   endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// ----------------------------------------------------------------------------
// alu_wb_stage_if
// Handshake/result bus between the ALU (master) and the write-back stage
// (slave).
//   in_valid     ALU result valid this cycle            (master -> slave)
//   in_ready     stage can accept                       (slave -> master)
//   in_opcode    instruction opcode                     (master -> slave)
//   in_rdest     destination register                   (master -> slave)
//   in_wen       instruction writes the register file   (master -> slave)
//   in_setflags  instruction updates the flags          (master -> slave)
//   in_dout      ALU result                             (master -> slave)
//   in_cout      ALU carry out                          (master -> slave)
//   in_vout      ALU overflow out                       (master -> slave)
//   in_qnz       DJNZ counter not zero                  (master -> slave)
//   in_mcp       multi-cycle operation                  (master -> slave)
// ----------------------------------------------------------------------------
interface alu_wb_stage_if #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned RADDR  = 4
);

   logic              in_valid;
   logic              in_ready;
   logic [5:0]        in_opcode;
   logic [RADDR-1:0]  in_rdest;
   logic              in_wen;
   logic              in_setflags;
   logic [DWIDTH-1:0] in_dout;
   logic              in_cout;
   logic              in_vout;
   logic              in_qnz;
   logic              in_mcp;

   modport master (
      output in_valid, in_opcode, in_rdest, in_wen, in_setflags,
             in_dout, in_cout, in_vout, in_qnz, in_mcp,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_opcode, in_rdest, in_wen, in_setflags,
             in_dout, in_cout, in_vout, in_qnz, in_mcp,
      output in_ready
   );

endinterface

// File: rtl/alu_mcp_ctrl.sv
// ----------------------------------------------------------------------------
// alu_mcp_ctrl
// IDLE/WAIT controller for multi-cycle ALU operations. An mcp op is held for
// MCP_CYCLES extra cycles before it is accepted; plain ops are accepted at once.
//   clk       system clock
//   reset_b   asynchronous active-low reset
//   i_valid   ALU result valid
//   i_mcp     ALU result needs extra cycles
//   o_ready   stage can accept (combinational)
//   o_accept  result is captured at the next edge (combinational)
// ----------------------------------------------------------------------------
module alu_mcp_ctrl
   import alu_wb_stage_pkg::*;
#(
   parameter int unsigned MCP_CYCLES = MCP_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_b,
   input  logic i_valid,
   input  logic i_mcp,
   output logic o_ready,
   output logic o_accept
);

   localparam int unsigned CntW = $clog2(MCP_CYCLES + 1);

   mcp_state_e    r_state;
   logic [CntW-1:0] r_cnt;
   logic          w_last;

   // The counter is loaded with MCP_CYCLES; the cycle whose decrement brings
   // it to zero is the capture cycle, giving 1+MCP_CYCLES edges of latency.
   assign w_last = (r_cnt == CntW'(1));

   always_comb begin
      o_ready  = 1'b1;
      o_accept = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_ready  = !(i_valid && i_mcp);
            o_accept = i_valid && !i_mcp;
         end
         StWait: begin
            o_ready  = w_last;
            o_accept = i_valid && w_last;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_valid && i_mcp) begin
                  r_cnt   <= CntW'(MCP_CYCLES);
                  r_state <= StWait;
               end
            end
            StWait: begin
               // Dropping valid mid-wait aborts the op without capture
               if (!i_valid || w_last) begin
                  r_cnt   <= '0;
                  r_state <= StIdle;
               end else begin
                  r_cnt <= r_cnt - CntW'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_wb_stage.sv
// ----------------------------------------------------------------------------
// alu_wb_stage
// Write-back stage after the ALU: registers result and write-port controls,
// owns the C/V/Z/S flag register and the DJNZ taken strobe, and stalls
// upstream for multi-cycle ops.
//   clk            system clock
//   reset_b        asynchronous active-low reset
//   up             ALU handshake/result bus (slave side)
//   wb_valid       registered result valid (one-cycle pulse per result)
//   wb_wen         register-file write enable
//   wb_rdest       register-file write address
//   wb_data        register-file write data
//   wb_djnz_taken  DJNZ branch-taken strobe
//   flag_c/v/z/s   architectural flags
// Optional (macro ALU_FLAG_FWD_EN):
//   nxt_flag_c/v/z/s  combinational value each flag takes at the next edge
// ----------------------------------------------------------------------------
module alu_wb_stage
   import alu_wb_stage_pkg::*;
#(
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned RADDR      = 4,
   parameter int unsigned MCP_CYCLES = MCP_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset_b,
   alu_wb_stage_if.slave     up,
   output logic              wb_valid,
   output logic              wb_wen,
   output logic [RADDR-1:0]  wb_rdest,
   output logic [DWIDTH-1:0] wb_data,
   output logic              wb_djnz_taken,
   output logic              flag_c,
   output logic              flag_v,
   output logic              flag_z,
   output logic              flag_s
`ifdef ALU_FLAG_FWD_EN
   ,
   output logic              nxt_flag_c,
   output logic              nxt_flag_v,
   output logic              nxt_flag_z,
   output logic              nxt_flag_s
`endif
);

   logic              w_accept;
   logic              w_ready;
   logic              w_is_cmp;
   logic              w_is_btst;
   logic              w_is_djnz;
   logic [3:0]        w_flags_nxt;

   logic              r_wb_valid;
   logic              r_wb_wen;
   logic [RADDR-1:0]  r_wb_rdest;
   logic [DWIDTH-1:0] r_wb_data;
   logic              r_wb_djnz;
   logic [3:0]        r_flags;

   alu_mcp_ctrl #(
      .MCP_CYCLES (MCP_CYCLES)
   ) u_mcp_ctrl (
      .clk      (clk),
      .reset_b  (reset_b),
      .i_valid  (up.in_valid),
      .i_mcp    (up.in_mcp),
      .o_ready  (w_ready),
      .o_accept (w_accept)
   );

   assign up.in_ready = w_ready;

   assign w_is_cmp  = (up.in_opcode == OP_CMP);
   assign w_is_btst = (up.in_opcode == OP_BTST);
   assign w_is_djnz = (up.in_opcode == OP_DJNZ);

   // CMP always sets flags; BTST only touches Z
   always_comb begin
      w_flags_nxt = r_flags;
      if (w_accept && (up.in_setflags || w_is_cmp)) begin
         w_flags_nxt[FLAG_Z] = (up.in_dout == '0);
         if (!w_is_btst) begin
            w_flags_nxt[FLAG_C] = up.in_cout;
            w_flags_nxt[FLAG_V] = up.in_vout;
            w_flags_nxt[FLAG_S] = up.in_dout[DWIDTH-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_wb_valid <= 1'b0;
         r_wb_wen   <= 1'b0;
         r_wb_rdest <= '0;
         r_wb_data  <= '0;
         r_wb_djnz  <= 1'b0;
         r_flags    <= '0;
      end else begin
         r_flags <= w_flags_nxt;
         if (w_accept) begin
            r_wb_valid <= 1'b1;
            r_wb_wen   <= up.in_wen && wen_allowed(up.in_opcode);
            r_wb_rdest <= up.in_rdest;
            r_wb_data  <= up.in_dout;
            r_wb_djnz  <= w_is_djnz && up.in_qnz;
         end else begin
            // Data and address hold so the forwarding path stays stable
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
            r_wb_djnz  <= 1'b0;
         end
      end
   end

   assign wb_valid      = r_wb_valid;
   assign wb_wen        = r_wb_wen;
   assign wb_rdest      = r_wb_rdest;
   assign wb_data       = r_wb_data;
   assign wb_djnz_taken = r_wb_djnz;
   assign flag_c        = r_flags[FLAG_C];
   assign flag_v        = r_flags[FLAG_V];
   assign flag_z        = r_flags[FLAG_Z];
   assign flag_s        = r_flags[FLAG_S];

`ifdef ALU_FLAG_FWD_EN
   assign nxt_flag_c = w_flags_nxt[FLAG_C];
   assign nxt_flag_v = w_flags_nxt[FLAG_V];
   assign nxt_flag_z = w_flags_nxt[FLAG_Z];
   assign nxt_flag_s = w_flags_nxt[FLAG_S];
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_wb_stage
// Directed testbench for alu_wb_stage with MCP_CYCLES=2.
// ----------------------------------------------------------------------------
module tb_alu_wb_stage;
   import alu_wb_stage_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned RA = 4;

   logic          clk;
   logic          reset_b;
   logic          wb_valid;
   logic          wb_wen;
   logic [RA-1:0] wb_rdest;
   logic [DW-1:0] wb_data;
   logic          wb_djnz_taken;
   logic          flag_c;
   logic          flag_v;
   logic          flag_z;
   logic          flag_s;
`ifdef ALU_FLAG_FWD_EN
   logic          nxt_flag_c;
   logic          nxt_flag_v;
   logic          nxt_flag_z;
   logic          nxt_flag_s;
`endif

   int n_checks;
   int n_pass;

   alu_wb_stage_if #(.DWIDTH(DW), .RADDR(RA)) u_if ();

   alu_wb_stage #(
      .DWIDTH     (DW),
      .RADDR      (RA),
      .MCP_CYCLES (2)
   ) u_dut (
      .clk           (clk),
      .reset_b       (reset_b),
      .up            (u_if),
      .wb_valid      (wb_valid),
      .wb_wen        (wb_wen),
      .wb_rdest      (wb_rdest),
      .wb_data       (wb_data),
      .wb_djnz_taken (wb_djnz_taken),
      .flag_c        (flag_c),
      .flag_v        (flag_v),
      .flag_z        (flag_z),
      .flag_s        (flag_s)
`ifdef ALU_FLAG_FWD_EN
      ,
      .nxt_flag_c    (nxt_flag_c),
      .nxt_flag_v    (nxt_flag_v),
      .nxt_flag_z    (nxt_flag_z),
      .nxt_flag_s    (nxt_flag_s)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] dout, input logic [3:0] rdest,
                        input logic wen, input logic setf, input logic cout,
                        input logic vout, input logic qnz, input logic mcp);
      u_if.in_valid    = 1'b1;
      u_if.in_opcode   = op;
      u_if.in_dout     = dout;
      u_if.in_rdest    = rdest;
      u_if.in_wen      = wen;
      u_if.in_setflags = setf;
      u_if.in_cout     = cout;
      u_if.in_vout     = vout;
      u_if.in_qnz      = qnz;
      u_if.in_mcp      = mcp;
   endtask

   task automatic idle_in();
      u_if.in_valid = 1'b0;
      u_if.in_mcp   = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_b  = 1'b0;
      drive(OP_ADD, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_in();

      // Reset state
      #3;
      check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_flags", {28'b0, flag_s, flag_z, flag_v, flag_c}, 32'd0);
      @(posedge clk);
      #2 reset_b = 1'b1;
      #1;
      check("rst_ready", {31'b0, u_if.in_ready}, 32'd1);

      // ADD: zero result with carry
      drive(OP_ADD, 32'h0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("add_ready", {31'b0, u_if.in_ready}, 32'd1);
      tick();
      idle_in();
      check("add_valid", {31'b0, wb_valid}, 32'd1);
      check("add_wen", {31'b0, wb_wen}, 32'd1);
      check("add_rdest", {28'b0, wb_rdest}, 32'd3);
      check("add_data", wb_data, 32'd0);
      check("add_flags_svzc", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b0011);
      tick();
      check("add_pulse_end", {30'b0, wb_valid, wb_wen}, 32'd0);

      // CMP: no write, flags update without setflags
      drive(OP_CMP, 32'h8000_0001, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle_in();
      check("cmp_valid", {31'b0, wb_valid}, 32'd1);
      check("cmp_wen", {31'b0, wb_wen}, 32'd0);
      check("cmp_flags_svzc", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b1100);

      // MUL with two extra cycles
      drive(OP_MUL, 32'h0001_0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      check("mul_ready_c0", {31'b0, u_if.in_ready}, 32'd0);
      tick();
      check("mul_valid_e1", {31'b0, wb_valid}, 32'd0);
      check("mul_ready_c1", {31'b0, u_if.in_ready}, 32'd0);
      tick();
      check("mul_valid_e2", {30'b0, wb_valid, wb_wen}, 32'd0);
      check("mul_ready_c2", {31'b0, u_if.in_ready}, 32'd1);
      tick();
      idle_in();
      check("mul_valid_e3", {31'b0, wb_valid}, 32'd1);
      check("mul_wen", {31'b0, wb_wen}, 32'd1);
      check("mul_data", wb_data, 32'h0001_0000);
      check("mul_rdest", {28'b0, wb_rdest}, 32'd7);
      check("mul_flags_held", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b1100);
      tick();
      check("mul_pulse_end", {31'b0, wb_valid}, 32'd0);

      // DJNZ taken then not taken, back to back
      drive(OP_DJNZ, 32'd5, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("djnz1_taken", {31'b0, wb_djnz_taken}, 32'd1);
      check("djnz1_wr", {30'b0, wb_valid, wb_wen}, 32'd3);
      check("djnz1_data", wb_data, 32'd5);
      drive(OP_DJNZ, 32'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      check("djnz2_taken", {31'b0, wb_djnz_taken}, 32'd0);
      check("djnz2_wr", {30'b0, wb_valid, wb_wen}, 32'd3);
      check("djnz2_data", wb_data, 32'd0);
      check("djnz_flags_held", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b1100);
      tick();
      check("djnz_pulse_end", {31'b0, wb_djnz_taken}, 32'd0);

      // BTST: Z only, no write
      drive(OP_BTST, 32'd0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      check("btst_wen", {31'b0, wb_wen}, 32'd0);
      check("btst_flags_svzc", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b1110);

      // Valid dropped mid-wait: abort, no capture
      drive(OP_MUL, 32'h0000_ffff, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      idle_in();
      #1;
      check("abort_ready_wait", {31'b0, u_if.in_ready}, 32'd0);
      tick();
      check("abort_no_valid", {31'b0, wb_valid}, 32'd0);
      tick();
      check("abort_no_valid2", {31'b0, wb_valid}, 32'd0);
      check("abort_rdest_held", {28'b0, wb_rdest}, 32'd4);
      check("abort_ready_idle", {31'b0, u_if.in_ready}, 32'd1);
      check("abort_flags_held", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b1110);

      // Reset during WAIT
      drive(OP_MUL, 32'h0000_0100, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      #2 reset_b = 1'b0;
      #1;
      check("wrst_flags", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'd0);
      check("wrst_rdest", {28'b0, wb_rdest}, 32'd0);
      check("wrst_valid", {31'b0, wb_valid}, 32'd0);
      idle_in();
      @(posedge clk);
      #2 reset_b = 1'b1;
      #1;
      check("wrst_ready", {31'b0, u_if.in_ready}, 32'd1);
      drive(OP_ADD, 32'h1234_5678, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      check("wrst_add_valid", {31'b0, wb_valid}, 32'd1);
      check("wrst_add_data", wb_data, 32'h1234_5678);
      check("wrst_add_rdest", {28'b0, wb_rdest}, 32'd9);
      check("wrst_add_flags", {28'b0, flag_s, flag_v, flag_z, flag_c}, 32'b0001);
      tick();

      // Ten back-to-back single-cycle ops
      for (int i = 0; i < 10; i++) begin
         drive(OP_ADD, 32'h100 + 32'(i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         check("b2b_ready", {31'b0, u_if.in_ready}, 32'd1);
         tick();
         check("b2b_valid", {31'b0, wb_valid}, 32'd1);
         check("b2b_data", wb_data, 32'h100 + 32'(i));
      end
      idle_in();
      tick();
      check("b2b_end", {31'b0, wb_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Downstream stage of the CPU ALU; registers the ALU result and flag outputs.
- Owns the architectural flag register (C, V, Z, S) and the DJNZ loop-test result.
- Sequences multi-cycle operations (ALU mcp_out asserted, e.g. 32x32 MUL) by stalling upstream for a fixed number of extra cycles.
- Drives the register-file write port, and doubles as the forwarding source for the next instruction.

Parameters:
- DWIDTH, 32, datapath width; must match the ALU.
- RADDR, 4, register-file address width.
- MCP_CYCLES, 1, extra cycles held for an operation that has in_mcp set; legal range 1..7.

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept; low while a multi-cycle op is pending
- in_opcode  in  6  opcode of the instruction, using the shared opcode defines
- in_rdest  in  RADDR  destination register
- in_wen  in  1  instruction writes the register file
- in_setflags  in  1  instruction updates the flags
- in_dout  in  DWIDTH  ALU dout
- in_cout  in  1  ALU cout
- in_vout  in  1  ALU vout
- in_qnz  in  1  ALU qnzout (DJNZ not-zero)
- in_mcp  in  1  ALU mcp_out
- wb_valid  out  1  registered result valid
- wb_wen  out  1  register-file write enable
- wb_rdest  out  RADDR  register-file write address
- wb_data  out  DWIDTH  register-file write data
- wb_djnz_taken  out  1  DJNZ branch-taken strobe
- flag_c  out  1  carry flag
- flag_v  out  1  overflow flag
- flag_z  out  1  zero flag
- flag_s  out  1  sign flag

Behaviour:
- Reset (asynchronous, reset_b low):
  - all outputs and registers go to 0; FSM to IDLE; in_ready=1 once reset_b is high.
  - A reset during WAIT aborts the pending op: no write, flags unchanged from reset.
- FSM states: IDLE and WAIT, with a cycle counter of width ceil(log2(MCP_CYCLES+1)).
- IDLE:
  - in_ready=1.
  - in_valid with in_mcp=0: accepted. On the next edge the wb_* registers load, wb_valid=1 for one cycle, and flags update.
  - in_valid with in_mcp=1: not accepted. in_ready drops combinationally to 0, the counter loads MCP_CYCLES, and the FSM goes to WAIT.
  - in_valid=0: wb_valid=0, wb_wen=0, wb_djnz_taken=0; wb_data and wb_rdest hold.
- WAIT:
  - in_ready=0; the counter decrements each cycle.
  - Upstream holds all in_* stable.
  - On the cycle the counter reaches 0, in_ready=1 and the result is captured as in IDLE; the FSM returns to IDLE.
  - Total latency for an mcp op is 1+MCP_CYCLES edges.
- in_valid dropping in WAIT is a protocol violation. Defined response: return to IDLE, no capture, flags unchanged.
- Write enable:
  - wb_wen = in_wen on accept.
  - Forced to 0 for CMP and BTST regardless of in_wen.
  - DJNZ writes the decremented counter when in_wen=1.
- Flags:
  - Update on accept when in_setflags=1, or unconditionally for CMP.
  - C=in_cout, V=in_vout, Z=(in_dout==0), S=in_dout[DWIDTH-1].
  - BTST updates Z only; C, V and S are held.
  - Otherwise all flags hold.
- DJNZ: wb_djnz_taken = in_qnz on accept of DJNZ, 0 otherwise; a one-cycle pulse.
- Back-to-back accepts every cycle must be supported, giving full throughput for non-mcp ops.

Optional Feature:
- Macro: ALU_FLAG_FWD_EN.
- Defined:
  - Adds output ports nxt_flag_c, nxt_flag_v, nxt_flag_z, nxt_flag_s.
  - Each is combinational and equals the value the corresponding flag takes at the next edge.
  - This lets the decoder feed carry-in into the ALU (cin/vin) for a dependent instruction with no bubble.
- Undefined:
  - Those ports are absent.
  - Upstream sees flags only one cycle after the flag-setting instruction is accepted; decode inserts the hazard stall.

Decomposition:
- Shared include cpu_2432.vh, which already holds the opcode defines (CMP, BTST, DJNZ, MUL), gains two additions:
  - flag bit positions FLAG_C/V/Z/S;
  - the default MCP_CYCLES.
- One sub-module, alu_mcp_ctrl: IDLE/WAIT FSM plus down-counter, outputs in_ready and accept.

Test Plan:
- ADD with in_dout=0x0000_0000, in_cout=1, in_setflags=1, in_wen=1, rdest=3 -> next cycle wb_wen=1, wb_rdest=3, wb_data=0, flag_z=1, flag_c=1, flag_s=0.
- CMP with in_wen=1, in_dout=0x8000_0001, in_vout=1 -> wb_wen=0; flag_s=1, flag_v=1, flag_z=0, even with in_setflags=0.
- MUL with in_mcp=1, MCP_CYCLES=2, in_dout=0x0001_0000 -> in_ready low for 2 cycles; wb_valid=1 exactly 3 edges after presentation; no earlier write.
- DJNZ with in_dout=5, in_qnz=1, then in_dout=0, in_qnz=0 -> wb_djnz_taken pulses 1 then 0; both results written; flags unchanged when in_setflags=0.
- reset_b asserted mid-WAIT -> all outputs 0 immediately; after release in_ready=1, a fresh ADD completes in 1 cycle.
- Ten back-to-back non-mcp ops -> ten consecutive wb_valid pulses with no bubbles and in_ready constantly 1.
